// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin arbiter sharing one bitwise logic unit between two requesters
// One result register serves both response channels; a grant may reload it on the cycle it drains.
module logic_unit_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_data,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_data
);

  logic             res_full;
  logic             res_owner;
  logic             last_grant;
  logic [WIDTH-1:0] res_data;

  logic             full_nxt;
  logic             owner_nxt;
  logic             last_nxt;
  logic [WIDTH-1:0] data_nxt;

  logic             drain;
  logic             grant_ok;
  logic             winner;
  logic             accept;

  function automatic logic [WIDTH-1:0] logic_op(input logic [1:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (op)
      2'b00:   logic_op = a & b;
      2'b01:   logic_op = a | b;
      2'b10:   logic_op = a ^ b;
      default: logic_op = ~(a | b);
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_full   <= 1'b0;
      res_owner  <= 1'b0;
      last_grant <= 1'b1;
      res_data   <= '0;
    end else begin
      res_full   <= full_nxt;
      res_owner  <= owner_nxt;
      last_grant <= last_nxt;
      res_data   <= data_nxt;
    end
  end

  always_comb begin
    drain     = res_full & (res_owner ? resp1_ready : resp0_ready);
    grant_ok  = ~res_full | drain;
    // Ties go to the requester not granted last; a lone requester always wins.
    winner    = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    accept    = grant_ok & (req0_valid | req1_valid);
    full_nxt  = res_full;
    owner_nxt = res_owner;
    last_nxt  = last_grant;
    data_nxt  = res_data;
    if (accept) begin
      full_nxt  = 1'b1;
      owner_nxt = winner;
      last_nxt  = winner;
      data_nxt  = winner ? logic_op(req1_op, req1_a, req1_b)
                         : logic_op(req0_op, req0_a, req0_b);
    end else if (drain) begin
      full_nxt = 1'b0;
    end
  end

  always_comb begin
    req0_ready  = accept & ~winner;
    req1_ready  = accept & winner;
    resp0_valid = res_full & ~res_owner;
    resp1_valid = res_full & res_owner;
    resp0_data  = res_data;
    resp1_data  = res_data;
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - vector table, hand sequences and random run against a queue model
module tb_logic_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op = 2'd0, req1_op = 2'd0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [31:0] resp0_data, resp1_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data)
  );

  typedef struct {
    logic        r0v;
    logic [1:0]  r0op;
    logic [31:0] r0a, r0b;
    logic        r1v;
    logic [1:0]  r1op;
    logic [31:0] r1a, r1b;
    logic        rr0, rr1;
    logic        e0rdy, e1rdy, ev0, ev1;
    logic [31:0] edata;
  } row_t;

  typedef struct {
    bit          owner;
    logic [31:0] data;
  } result_t;

  function automatic row_t mk(logic r0v, logic [1:0] r0op, logic [31:0] r0a, logic [31:0] r0b,
                              logic r1v, logic [1:0] r1op, logic [31:0] r1a, logic [31:0] r1b,
                              logic rr0, logic rr1, logic e0rdy, logic e1rdy,
                              logic ev0, logic ev1, logic [31:0] edata);
    row_t r;
    r.r0v = r0v; r.r0op = r0op; r.r0a = r0a; r.r0b = r0b;
    r.r1v = r1v; r.r1op = r1op; r.r1a = r1a; r.r1b = r1b;
    r.rr0 = rr0; r.rr1 = rr1;
    r.e0rdy = e0rdy; r.e1rdy = e1rdy; r.ev0 = ev0; r.ev1 = ev1; r.edata = edata;
    return r;
  endfunction

  function automatic logic [31:0] ref_op(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    if (op == 2'd0)      r = a & b;
    else if (op == 2'd1) r = a | b;
    else if (op == 2'd2) r = a ^ b;
    else                 r = ~(a | b);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_row(input row_t r, input string tag);
    req0_valid = r.r0v; req0_op = r.r0op; req0_a = r.r0a; req0_b = r.r0b;
    req1_valid = r.r1v; req1_op = r.r1op; req1_a = r.r1a; req1_b = r.r1b;
    resp0_ready = r.rr0; resp1_ready = r.rr1;
    @(negedge clk);
    chk({tag, " req0_ready"},  {31'd0, req0_ready},  {31'd0, r.e0rdy});
    chk({tag, " req1_ready"},  {31'd0, req1_ready},  {31'd0, r.e1rdy});
    chk({tag, " resp0_valid"}, {31'd0, resp0_valid}, {31'd0, r.ev0});
    chk({tag, " resp1_valid"}, {31'd0, resp1_valid}, {31'd0, r.ev1});
    chk({tag, " resp0_data"},  resp0_data, r.edata);
    chk({tag, " resp1_data"},  resp1_data, r.edata);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset resp0_valid", {31'd0, resp0_valid}, 32'd0);
    chk("reset resp1_valid", {31'd0, resp1_valid}, 32'd0);
    chk("reset resp0_data", resp0_data, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  row_t tbl[11];
  row_t bp[7];

  initial begin
    result_t     q[$];
    bit          last;
    bit          hold0, hold1;
    logic        e0, e1, dr, any;

    tbl[0]  = mk(1, 2'd1, 32'hF0F0_0000, 32'h0000_0F0F, 0, 2'd0, 0, 0, 1, 1, 1, 0, 0, 0, 32'h0);
    tbl[1]  = mk(0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 1, 1, 0, 0, 1, 0, 32'hF0F0_0F0F);
    tbl[2]  = mk(0, 2'd0, 0, 0, 1, 2'd2, 32'hFFFF_FFFF, 32'h1234_5678, 1, 1, 0, 1, 0, 0, 32'hF0F0_0F0F);
    tbl[3]  = mk(0, 2'd0, 0, 0, 1, 2'd0, 32'hFF00_FF00, 32'h0F0F_0F0F, 1, 1, 0, 1, 0, 1, 32'hEDCB_A987);
    tbl[4]  = mk(0, 2'd0, 0, 0, 1, 2'd3, 32'h0, 32'h0, 1, 1, 0, 1, 0, 1, 32'h0F00_0F00);
    tbl[5]  = mk(0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 1, 1, 0, 0, 0, 1, 32'hFFFF_FFFF);
    tbl[6]  = mk(1, 2'd1, 1, 2, 1, 2'd2, 3, 5, 1, 1, 1, 0, 0, 0, 32'hFFFF_FFFF);
    tbl[7]  = mk(1, 2'd1, 1, 2, 1, 2'd2, 3, 5, 1, 1, 0, 1, 1, 0, 32'h3);
    tbl[8]  = mk(1, 2'd1, 1, 2, 1, 2'd2, 3, 5, 1, 1, 1, 0, 0, 1, 32'h6);
    tbl[9]  = mk(1, 2'd1, 1, 2, 1, 2'd2, 3, 5, 1, 1, 0, 1, 1, 0, 32'h3);
    tbl[10] = mk(0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 1, 1, 0, 0, 0, 1, 32'h6);

    bp[0] = mk(1, 2'd0, 32'hFFFF_0000, 32'h0F0F_0F0F, 1, 2'd1, 1, 0, 0, 1, 1, 0, 0, 0, 32'h6);
    bp[1] = mk(0, 2'd0, 0, 0, 1, 2'd1, 1, 0, 0, 1, 0, 0, 1, 0, 32'h0F0F_0000);
    bp[2] = bp[1];
    bp[3] = bp[1];
    bp[4] = mk(0, 2'd0, 0, 0, 1, 2'd1, 1, 0, 1, 1, 0, 1, 1, 0, 32'h0F0F_0000);
    bp[5] = mk(0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1);

    repeat (2) @(posedge clk);
    #1;
    chk("reset resp0_valid", {31'd0, resp0_valid}, 32'd0);
    chk("reset resp1_valid", {31'd0, resp1_valid}, 32'd0);
    chk("reset resp0_data", resp0_data, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_row(tbl[i], $sformatf("tbl%0d", i));
    for (int i = 0; i < 6; i++)  run_row(bp[i], $sformatf("bp%0d", i));

    pulse_reset();
    run_row(mk(1, 2'd2, 32'hAAAA_5555, 32'hFFFF_0000, 1, 2'd1, 1, 2, 1, 1, 1, 0, 0, 0, 32'h0), "post_rst0");
    run_row(mk(0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 1, 1, 0, 0, 1, 0, 32'h5555_5555), "post_rst1");

    pulse_reset();
    last  = 1'b1;
    hold0 = 1'b0;
    hold1 = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!hold0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_op    = 2'($urandom_range(0, 3));
        req0_a     = $urandom;
        req0_b     = $urandom;
      end
      if (!hold1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_op    = 2'($urandom_range(0, 3));
        req1_a     = $urandom;
        req1_b     = $urandom;
      end
      resp0_ready = ($urandom_range(0, 3) != 0);
      resp1_ready = ($urandom_range(0, 3) != 0);

      // Model: the result slot is a one-deep queue; a grant needs the slot empty or leaving.
      dr  = (q.size() != 0) && (q[0].owner ? resp1_ready : resp0_ready);
      any = (q.size() == 0) || dr;
      e0  = any && req0_valid && (!req1_valid || last == 1'b1);
      e1  = any && req1_valid && (!req0_valid || last == 1'b0);

      @(negedge clk);
      chk("rand req0_ready", {31'd0, req0_ready}, {31'd0, e0});
      chk("rand req1_ready", {31'd0, req1_ready}, {31'd0, e1});
      chk("rand resp0_valid", {31'd0, resp0_valid}, {31'd0, (q.size() != 0) && !q[0].owner});
      chk("rand resp1_valid", {31'd0, resp1_valid}, {31'd0, (q.size() != 0) && q[0].owner});
      if (q.size() != 0)
        chk(q[0].owner ? "rand resp1_data" : "rand resp0_data",
            q[0].owner ? resp1_data : resp0_data, q[0].data);

      @(posedge clk);
      if (dr) void'(q.pop_front());
      if (e0) begin q.push_back('{owner: 1'b0, data: ref_op(req0_op, req0_a, req0_b)}); last = 1'b0; end
      if (e1) begin q.push_back('{owner: 1'b1, data: ref_op(req1_op, req1_a, req1_b)}); last = 1'b1; end
      hold0 = req0_valid && !e0;
      hold1 = req1_valid && !e1;
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
